// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: mode control inputs and LED/fan/step outputs of the pattern generator
interface led_pattern_gen_if #(parameter int LED_NUM = 4);
  logic [1:0]         mode;
  logic               mode_vld;
  logic               pause;
  logic               fan;
  logic [LED_NUM-1:0] led;
  logic               step_pulse;
  modport master(output mode, mode_vld, pause, input fan, led, step_pulse);
  modport slave(input mode, mode_vld, pause, output fan, led, step_pulse);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: tick-paced LED patterns (blink, chase, bounce, PWM breathe) with pause and mode reload
module led_pattern_gen #(
  parameter int          LED_NUM  = 4,
  parameter int unsigned TICK_CNT = 32'd50_000_000,
  parameter int          PWM_BITS = 8
) (
  input logic             sys_clk,
  input logic             resetn,
  led_pattern_gen_if.slave bus
);
  typedef enum logic [1:0] {BLINK, CHASE, BOUNCE, BREATHE} mode_e;
  localparam int TW = $clog2(TICK_CNT);
  localparam logic [PWM_BITS-1:0] DMAX = '1;
  if (LED_NUM < 1 || LED_NUM > 32 || TICK_CNT < 2 || PWM_BITS < 2 || PWM_BITS > 12) begin : g_bad_param
    $error("led_pattern_gen: parameter out of range");
  end
  mode_e               mode_q, mode_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [LED_NUM-1:0]  led_q, led_d, bnc;
  logic [PWM_BITS-1:0] pwm_q, pwm_d, duty_q, duty_d, duty_n;
  logic                dir_q, dir_d, step_q, step_d, fan_q, wrap;
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      mode_q <= BLINK;
      tick_q <= '0;
      led_q  <= '0;
      pwm_q  <= '0;
      duty_q <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      fan_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      tick_q <= tick_d;
      led_q  <= led_d;
      pwm_q  <= pwm_d;
      duty_q <= duty_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      fan_q  <= 1'b1;
    end
  end
  // dir_q is shared by bounce and breathe; 1 means moving down
  always_comb begin
    mode_d = mode_q;
    tick_d = tick_q;
    led_d  = led_q;
    pwm_d  = pwm_q;
    duty_d = duty_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap   = tick_q == TW'(TICK_CNT - 1);
    bnc    = dir_q ? led_q >> 1 : led_q << 1;
    duty_n = dir_q ? duty_q - 1'b1 : duty_q + 1'b1;
    if (bus.mode_vld) begin
      mode_d = mode_e'(bus.mode);
      tick_d = '0;
      pwm_d  = '0;
      duty_d = '0;
      dir_d  = 1'b0;
      led_d  = (bus.mode == 2'd1 || bus.mode == 2'd2) ? LED_NUM'(1) : '0;
    end else if (!bus.pause) begin
      tick_d = wrap ? '0 : tick_q + 1'b1;
      pwm_d  = pwm_q + 1'b1;
      step_d = wrap;
      case (mode_q)
        BLINK: if (wrap) led_d = ~led_q;
        CHASE: if (wrap) led_d = (led_q << 1) | (led_q >> (LED_NUM - 1));
        BOUNCE: if (wrap && LED_NUM > 1) begin
          led_d = bnc;
          dir_d = bnc[LED_NUM-1] | (dir_q & ~bnc[0]);
        end
        default: begin
          led_d = {LED_NUM{pwm_q < duty_q}};
          if (wrap) begin
            duty_d = duty_n;
            dir_d  = (duty_n == DMAX) | (dir_q & (duty_n != '0));
          end
        end
      endcase
    end
  end
  assign bus.led        = led_q;
  assign bus.step_pulse = step_q;
  assign bus.fan        = fan_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed vector table, breathe/reset corners, and random run against a step-index reference model
module tb_led_pattern_gen;
  localparam int N = 4, T = 4, PB = 2, PM = (1 << PB) - 1, ALL = (1 << N) - 1;
  logic sys_clk = 1'b0, resetn = 1'b0;
  always #5 sys_clk = ~sys_clk;
  led_pattern_gen_if #(.LED_NUM(N)) bus();
  led_pattern_gen #(.LED_NUM(N), .TICK_CNT(T), .PWM_BITS(PB)) dut (.sys_clk(sys_clk), .resetn(resetn), .bus(bus));
  typedef struct {logic vld; logic [1:0] mode; logic pause; int n; int led; int steps;} vec_t;
  vec_t tbl[$];
  int errs = 0, checks = 0;
  int m_mode, m_cnt, m_k, m_pwm, e_led, e_step, e_fan;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int pat(input int md, input int k);
    int p;
    p = k % (2 * N - 2);
    case (md)
      0: return (k % 2) ? ALL : 0;
      1: return 1 << (k % N);
      2: return 1 << (p < N ? p : 2 * N - 2 - p);
      default: return 0;
    endcase
  endfunction
  function automatic int duty(input int k);
    int p;
    p = k % (2 * PM);
    return p <= PM ? p : 2 * PM - p;
  endfunction
  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_k = 0; m_pwm = 0; e_led = 0; e_step = 0; e_fan = 0;
  endtask
  // model tracks steps since the last load; patterns are closed-form functions of that index
  task automatic model_edge(input int md, input logic v, input logic p);
    logic b;
    e_fan = 1;
    if (v) begin
      m_mode = md; m_cnt = 0; m_k = 0; m_pwm = 0; e_step = 0;
      e_led = (md == 1 || md == 2) ? 1 : 0;
    end else if (!p) begin
      b = m_pwm < duty(m_k);
      e_step = (m_cnt == T - 1) ? 1 : 0;
      m_k += e_step;
      m_cnt = (m_cnt + 1) % T;
      m_pwm = (m_pwm + 1) % (1 << PB);
      e_led = (m_mode == 3) ? (b ? ALL : 0) : pat(m_mode, m_k);
    end else e_step = 0;
  endtask
  task automatic cyc(input logic [1:0] md, input logic v, input logic p);
    bus.mode = md; bus.mode_vld = v; bus.pause = p;
    @(posedge sys_clk);
    model_edge(md, v, p);
    @(negedge sys_clk);
    bus.mode_vld = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge sys_clk);
    resetn = 1'b0;
    model_reset();
    #1;
    check("reset led", bus.led, 0);
    check("reset step", bus.step_pulse, 0);
    check("reset fan", bus.fan, 0);
    @(negedge sys_clk);
    resetn = 1'b1;
  endtask
  function automatic void add(input logic v, input logic [1:0] m, input logic p, input int n, input int l, input int s);
    vec_t e;
    e.vld = v; e.mode = m; e.pause = p; e.n = n; e.led = l; e.steps = s;
    tbl.push_back(e);
  endfunction
  initial begin
    int steps, hi;
    logic p;
    bus.mode = 2'd0; bus.mode_vld = 1'b0; bus.pause = 1'b0;
    add(0, 0, 0, 1, 0, 0); add(0, 0, 0, 3, ALL, 1); add(0, 0, 0, 4, 0, 1);
    add(1, 1, 0, 1, 1, 0); add(0, 0, 0, 4, 2, 1); add(0, 0, 0, 4, 4, 1);
    add(0, 0, 0, 4, 8, 1); add(0, 0, 0, 4, 1, 1);
    add(0, 0, 0, 2, 1, 0); add(0, 0, 1, 10, 1, 0); add(0, 0, 0, 2, 2, 1);
    add(1, 2, 0, 1, 1, 0); add(0, 0, 0, 4, 2, 1); add(0, 0, 0, 4, 4, 1);
    add(0, 0, 0, 4, 8, 1); add(0, 0, 0, 4, 4, 1); add(0, 0, 0, 4, 2, 1);
    add(0, 0, 0, 4, 1, 1); add(0, 0, 0, 4, 2, 1);
    add(1, 1, 1, 1, 1, 0); add(0, 0, 1, 5, 1, 0); add(0, 0, 0, 4, 2, 1);
    add(1, 1, 0, 1, 1, 0); add(0, 0, 0, 3, 1, 0); add(1, 3, 0, 1, 0, 0);
    add(0, 0, 0, 4, 0, 1);
    do_reset();
    foreach (tbl[i]) begin
      steps = 0;
      for (int j = 0; j < tbl[i].n; j++) begin
        cyc(tbl[i].mode, tbl[i].vld && j == 0, tbl[i].pause);
        steps += int'(bus.step_pulse);
        if (i == 0) check("fan after release", bus.fan, 1);
      end
      check($sformatf("vec%0d led", i), bus.led, tbl[i].led);
      check($sformatf("vec%0d steps", i), steps, tbl[i].steps);
    end
    steps = 0;
    for (int j = 0; j < 4; j++) begin
      cyc(0, 0, 0);
      steps += int'(bus.step_pulse);
    end
    check("breathe duty1 steps", steps, 1);
    hi = 0;
    for (int j = 0; j < 4; j++) begin
      cyc(0, 0, 0);
      hi += (bus.led == ALL) ? 1 : 0;
    end
    check("breathe duty2 on-cycles", hi, 2);
    cyc(0, 0, 0);
    check("breathe duty3 led", bus.led, ALL);
    resetn = 1'b0;
    #1;
    check("mid-breathe reset led", bus.led, 0);
    check("mid-breathe reset fan", bus.fan, 0);
    check("mid-breathe reset step", bus.step_pulse, 0);
    do_reset();
    p = 1'b0;
    for (int j = 0; j < 2000; j++) begin
      if ($urandom_range(0, 9) == 0) p = ~p;
      cyc(2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0, p);
      check($sformatf("rnd%0d led", j), bus.led, e_led);
      check($sformatf("rnd%0d step/fan", j), {bus.step_pulse, bus.fan}, {e_step[0], e_fan[0]});
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
